// File: rtl/mem_responder.sv
// Single-port memory slave driven by a microcoded controller.
// A command is accepted once in IDLE; REARM waits for an idle command so a held command runs only once.
module mem_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [1:0]        mcontrol,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, REARM} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    logic w_acceptRd;
    logic w_acceptWr;
    logic w_rdDone;
    logic w_memWe;
    logic w_setErr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_acceptRd  = 1'b0;
        w_acceptWr  = 1'b0;
        w_rdDone    = 1'b0;
        w_memWe     = 1'b0;
        w_setErr    = 1'b0;
        case (r_state)
            IDLE: begin
                case (mcontrol)
                    2'b01: begin
                        w_acceptRd  = 1'b1;
                        w_nextState = RD_WAIT;
                    end
                    2'b10: begin
                        w_acceptWr  = 1'b1;
                        w_nextState = WR;
                    end
                    2'b11: begin
                        w_setErr    = 1'b1;
                        w_nextState = REARM;
                    end
                    default: ;
                endcase
            end
            RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_rdDone    = 1'b1;
                    w_nextState = REARM;
                end
            end
            WR: begin
                w_memWe     = 1'b1;
                w_nextState = REARM;
            end
            REARM: begin
                if (mcontrol == 2'b00) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Operands are captured only at accept, so later input changes cannot disturb an access.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_rdDone | w_memWe;
            if (w_acceptRd || w_acceptWr) begin
                r_addr <= addr;
            end
            if (w_acceptWr) begin
                r_wdata <= wdata;
            end
            if (w_acceptRd) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == RD_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_rdDone) begin
                r_rdata <= r_mem[r_addr];
            end
            if (w_setErr) begin
                r_err <= 1'b1;
            end
        end
    end

    // The array has no reset so contents survive resetn.
    always_ff @(posedge clock) begin
        if (w_memWe) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign rdata = r_rdata;
    assign done  = r_done;
    assign busy  = (r_state == RD_WAIT) || (r_state == WR);
    assign err   = r_err;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- DATA_W, 8, data word width.
- ADDR_W, 8, address width; memory depth 2**ADDR_W words.
- RD_LAT, 2, read latency in clock cycles; legal range 1..8.

REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all state updates on its rising edge.
- resetn, in, 1, asynchronous active-low reset.
- mcontrol, in, 2, command from the microcoded controller: 00 idle, 01 read, 10 write, 11 illegal.
- addr, in, ADDR_W, word address, sampled on accept.
- wdata, in, DATA_W, write data, sampled on accept.
- rdata, out, DATA_W, registered read data; holds its value until the next read completes.
- done, out, 1, one-cycle completion pulse.
- busy, out, 1, high while an access is in flight.
- err, out, 1, sticky flag for an illegal command.

Function
REQ-003 The FSM SHALL have four states: IDLE, RD_WAIT, WR, REARM.
REQ-004 In IDLE, mcontrol=01 at edge k SHALL be accepted: addr is latched, the latency counter is loaded with RD_LAT-1, and the FSM moves to RD_WAIT.
REQ-005 In RD_WAIT:
- counter>0: decrement.
- counter==0: rdata<=mem[addr_q], done<=1, move to REARM.
- Net effect: read data is valid and done is high in the cycle after edge k+RD_LAT.
REQ-006 In IDLE, mcontrol=10 at edge k SHALL latch addr and wdata and move to WR.
REQ-007 In WR, edge k+1 SHALL perform mem[addr_q]<=wdata_q, set done<=1, and move to REARM.
REQ-008 In IDLE, mcontrol=11 SHALL perform no memory access, assert no done, set err<=1 and move to REARM.
REQ-009 In REARM, the FSM SHALL stay until it samples mcontrol==00, then move to IDLE.
- A level-held command is therefore executed exactly once.
REQ-010 In IDLE, mcontrol=00 SHALL keep the FSM in IDLE with no side effects.
REQ-011 busy SHALL be high exactly when the state is RD_WAIT or WR.
REQ-012 done SHALL be high for exactly one cycle per completed read or write, and never for an illegal command.
REQ-013 Changes on mcontrol, addr or wdata while in RD_WAIT, WR or REARM SHALL be ignored; the access uses only the values latched at accept.
REQ-014 The earliest back-to-back sequence SHALL be: accept at edge k, REARM, mcontrol=00 sampled, IDLE, next accept.
- Minimum command spacing is RD_LAT+2 cycles for reads and 3 cycles for writes.
REQ-015 Every address in 0..2**ADDR_W-1 SHALL be valid; there is no wrap or out-of-range case.
REQ-016 err SHALL stay set once set, and only resetn SHALL clear it.

Reset
REQ-017 resetn=0 SHALL asynchronously force: state=IDLE, rdata=0, done=0, busy=0, err=0, latency counter=0, latched addr/wdata=0.
REQ-018 Memory array contents SHALL NOT be altered by reset; simulation initialises the array to zero.
REQ-019 Reset asserted while in WR before the write edge SHALL abort the write, leaving memory unchanged.
REQ-020 Reset asserted while in RD_WAIT SHALL abort the read, leave rdata=0 and produce no done.
REQ-021 If mcontrol is non-zero when resetn deasserts, the command SHALL be accepted at the first rising edge after deassertion.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Write then read: write 0xA5 to address 0x10, then read 0x10 with RD_LAT=2 -> rdata=0xA5 with done high in the cycle after accept edge+2; busy high for exactly 2 cycles.
- Held command: mcontrol=10 held for 6 cycles with addr=0x03, wdata=0x11 -> one write and one done pulse; wdata changed to 0x22 in cycle 2 -> mem[0x03]=0x11.
- Illegal command: mcontrol=11 -> err=1, done stays 0, memory unchanged; a subsequent legal read completes normally with err still 1.
- Reset mid-write: reset asserted one cycle after write accept to 0x20 (prior value 0x00) -> mem[0x20]=0x00, all outputs 0.
- Address boundaries: write 0xFF to address 0xFF and 0x01 to address 0x00 -> reads return 0xFF and 0x01 respectively.
- Latency sweep: RD_LAT=1 and RD_LAT=8 -> done exactly 1 and 8 edges after accept; busy width matches RD_LAT.
